multicore_collector: RTL

- Sits directly downstream of the multicore array of rede_float cores.
- Watches every core's io_out / out_en pair and captures each finished result exactly once.
- Tags each result with its core index and queues it in a FIFO.
- Replaces the combinational priority mux with a lossless round-robin collector behind a valid/ready output handshake.

---
 rtl/multicore_pkg.sv | 30 +++
 rtl/collector_fifo.sv | 66 ++++++
 rtl/multicore_collector.sv | 125 ++++++++++++
 3 files changed

// File: rtl/multicore_pkg.sv
// ============================================================================
// multicore_pkg : shared constants, result record and arbiter index helper
// Rev 1.0
// ============================================================================
`default_nettype none

package multicore_pkg;

  localparam int N_CORES = 33;
  localparam int DATA_W  = 28;
  localparam int EN_W    = 4;
  localparam int ID_W    = 6;
  localparam logic [EN_W-1:0] EN_CODE = EN_W'(1);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } result_t;

  // Slot index base+off with wrap at N_CORES (off < N_CORES).
  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_CORES) sum = sum - N_CORES;
    return ID_W'(sum);
  endfunction

endpackage

`default_nettype wire

// File: rtl/collector_fifo.sv
// ============================================================================
// collector_fifo : synchronous FIFO of result_t, fall-through head
// Rev 1.0
// ============================================================================
`default_nettype none

module collector_fifo
  import multicore_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  result_t          push_data,
  input  logic             pop,
  output result_t          head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  result_t          mem_q [DEPTH];
  result_t          mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q] = push_data;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/multicore_collector.sv
// ============================================================================
// multicore_collector : edge-captures core results, round-robin into a FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module multicore_collector
  import multicore_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CORES*DATA_W-1:0] core_io_out,
  input  logic [N_CORES*EN_W-1:0]   core_out_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [DATA_W-1:0]  out_data,
  output logic [ID_W-1:0]           out_core_id,
  output logic [N_CORES-1:0]        overflow,
  output logic [CNT_W-1:0]          fifo_count,
  output logic [15:0]               result_cnt
);

  logic [N_CORES-1:0][EN_W-1:0]   prev_en_q, prev_en_d;
  logic [N_CORES-1:0]             pend_vld_q, pend_vld_d;
  logic [N_CORES-1:0][DATA_W-1:0] pend_data_q, pend_data_d;
  logic [N_CORES-1:0]             overflow_q, overflow_d;
  logic [ID_W-1:0]                ptr_q, ptr_d;
  logic [15:0]                    result_cnt_q, result_cnt_d;

  logic [N_CORES-1:0] strobe;
  logic               found, grant, pop, push_ok, fifo_full, fifo_empty;
  logic [ID_W-1:0]    grant_idx, cand;
  result_t            push_data, head;

  always_comb begin
    strobe       = '0;
    prev_en_d    = prev_en_q;
    found        = 1'b0;
    grant_idx    = '0;
    cand         = '0;
    pend_vld_d   = pend_vld_q;
    pend_data_d  = pend_data_q;
    overflow_d   = overflow_q;

    pop     = out_valid && out_ready;
    push_ok = !fifo_full || pop;

    for (int k = 0; k < N_CORES; k++) begin
      prev_en_d[k] = core_out_en[k*EN_W +: EN_W];
      strobe[k]    = (core_out_en[k*EN_W +: EN_W] == EN_CODE) && (prev_en_q[k] != EN_CODE);
    end

    for (int i = 0; i < N_CORES; i++) begin
      cand = rr_index(ptr_q, i);
      if (!found && pend_vld_q[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    grant = found && push_ok;

    // A slot granted this cycle is free to take a same-cycle strobe.
    for (int k = 0; k < N_CORES; k++) begin
      if (grant && (grant_idx == ID_W'(k))) pend_vld_d[k] = 1'b0;
      if (strobe[k]) begin
        if (pend_vld_q[k] && !(grant && (grant_idx == ID_W'(k)))) begin
          overflow_d[k] = 1'b1;
        end else begin
          pend_vld_d[k]  = 1'b1;
          pend_data_d[k] = core_io_out[k*DATA_W +: DATA_W];
        end
      end
    end

    ptr_d = ptr_q;
    if (grant) ptr_d = (grant_idx == ID_W'(N_CORES - 1)) ? '0 : grant_idx + 1'b1;

    push_data.id   = grant_idx;
    push_data.data = pend_data_q[grant_idx];
    result_cnt_d   = result_cnt_q + 16'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_en_q    <= '0;
      pend_vld_q   <= '0;
      pend_data_q  <= '0;
      overflow_q   <= '0;
      ptr_q        <= '0;
      result_cnt_q <= '0;
    end else begin
      prev_en_q    <= prev_en_d;
      pend_vld_q   <= pend_vld_d;
      pend_data_q  <= pend_data_d;
      overflow_q   <= overflow_d;
      ptr_q        <= ptr_d;
      result_cnt_q <= result_cnt_d;
    end
  end

  collector_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (grant),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Head fields read as zero while the queue is empty.
  assign out_valid   = !fifo_empty;
  assign out_data    = out_valid ? head.data : '0;
  assign out_core_id = out_valid ? head.id : '0;
  assign overflow    = overflow_q;
  assign result_cnt  = result_cnt_q;

endmodule

`default_nettype wire
